// File: rtl/riscv_pu_memory_unit.sv
// Memory-access stage: issues one AXI4-Lite read or write per load/store,
// stalls upstream until the response, then registers the MEM/WB bundle.
module riscv_pu_memory_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic [2:0]            i_width,
  input  logic                  i_jump,
  input  logic                  i_rd_write,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic                  i_wb_src,
  input  logic                  i_valid_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_alu_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic [4:0]            i_rd_addr,
  output logic                  o_stall,
  output logic                  o_jump,
  output logic                  o_rd_write,
  output logic                  o_wb_src,
  output logic                  o_valid_instr,
  output logic                  o_mem_err,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_alu_data,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [4:0]            o_rd_addr,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [7:0]            m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_wstrb;
  logic [2:0]            r_width;
  logic                  r_aw_done, r_w_done;
  // Response that arrived while enable=0; retired on the next enabled cycle.
  logic                  r_pend, r_pend_err;
  logic [DATA_WIDTH-1:0] r_pend_data;

  logic [2:0]            w_lane;
  logic                  w_misal, w_memop, w_start, w_done, w_resp_err;
  logic [7:0]            w_strb_base;
  logic [DATA_WIDTH-1:0] w_sh, w_fmt, w_done_data;

  assign w_lane  = i_alu_data[2:0];
  assign w_memop = i_valid_instr && (i_read || i_write) && enable;

  always_comb begin
    case (i_width[1:0])
      2'b00:   begin w_misal = 1'b0;             w_strb_base = 8'h01; end
      2'b01:   begin w_misal = i_alu_data[0];    w_strb_base = 8'h03; end
      2'b10:   begin w_misal = |i_alu_data[1:0]; w_strb_base = 8'h0F; end
      default: begin w_misal = |i_alu_data[2:0]; w_strb_base = 8'hFF; end
    endcase
  end

  assign w_start = (r_state == S_IDLE) && w_memop && !w_misal && !r_pend;
  assign w_done  = ((r_state == S_RD_DATA) && m_rvalid) || ((r_state == S_WR_RESP) && m_bvalid);
  assign o_stall = ((r_state != S_IDLE) && !w_done) || w_start;

  assign w_sh = m_rdata >> {r_addr[2:0], 3'b000};
  always_comb begin
    case (r_width)
      3'b000:  w_fmt = {{(DATA_WIDTH-8){w_sh[7]}},   w_sh[7:0]};
      3'b001:  w_fmt = {{(DATA_WIDTH-16){w_sh[15]}}, w_sh[15:0]};
      3'b010:  w_fmt = {{(DATA_WIDTH-32){w_sh[31]}}, w_sh[31:0]};
      3'b100:  w_fmt = {{(DATA_WIDTH-8){1'b0}},      w_sh[7:0]};
      3'b101:  w_fmt = {{(DATA_WIDTH-16){1'b0}},     w_sh[15:0]};
      3'b110:  w_fmt = {{(DATA_WIDTH-32){1'b0}},     w_sh[31:0]};
      default: w_fmt = m_rdata;
    endcase
  end

  assign w_resp_err  = (r_state == S_RD_DATA) ? (m_rresp != 2'b00) : (m_bresp != 2'b00);
  assign w_done_data = (r_state == S_RD_DATA) ? w_fmt : '0;

  // FSM: state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM: next state (bus handshakes progress independently of enable)
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = i_read ? S_RD_ADDR : S_WR_REQ;
      S_RD_ADDR: if (m_arready) w_next = S_RD_DATA;
      S_RD_DATA: if (m_rvalid) w_next = S_IDLE;
      S_WR_REQ:  if ((r_aw_done || m_awready) && (r_w_done || m_wready)) w_next = S_WR_RESP;
      S_WR_RESP: if (m_bvalid) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // FSM: bus outputs
  always_comb begin
    m_arvalid = (r_state == S_RD_ADDR);
    m_rready  = (r_state == S_RD_DATA);
    m_awvalid = (r_state == S_WR_REQ) && !r_aw_done;
    m_wvalid  = (r_state == S_WR_REQ) && !r_w_done;
    m_bready  = (r_state == S_WR_RESP);
    m_araddr  = m_arvalid ? r_addr  : '0;
    m_awaddr  = m_awvalid ? r_addr  : '0;
    m_wdata   = m_wvalid  ? r_wdata : '0;
    m_wstrb   = m_wvalid  ? r_wstrb : '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_width     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_err  <= 1'b0;
      r_pend_data <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= i_alu_data[ADDR_WIDTH-1:0];
        r_wdata <= i_rs2_data << {w_lane, 3'b000};
        r_wstrb <= w_strb_base << w_lane;
        r_width <= i_width;
      end
      if (r_state == S_WR_REQ) begin
        if (w_next == S_WR_RESP) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          if (m_awvalid && m_awready) r_aw_done <= 1'b1;
          if (m_wvalid && m_wready)   r_w_done  <= 1'b1;
        end
      end
      if (w_done && !enable) begin
        r_pend      <= 1'b1;
        r_pend_err  <= w_resp_err;
        r_pend_data <= w_done_data;
      end else if ((r_state == S_IDLE) && enable) begin
        r_pend <= 1'b0;
      end
    end
  end

  // MEM/WB next values; w_wb_ld=0 holds the registers
  logic                  w_wb_ld, w_nx_vld, w_nx_err, w_nx_rdw, w_nx_jump, w_nx_wbs;
  logic [DATA_WIDTH-1:0] w_nx_pc, w_nx_alu, w_nx_mem;
  logic [4:0]            w_nx_rd;
  logic                  w_bubble;

  always_comb begin
    w_wb_ld   = 1'b0;
    w_bubble  = 1'b0;
    w_nx_err  = 1'b0;
    w_nx_mem  = '0;
    if (enable) begin
      w_wb_ld = 1'b1;
      if (w_done) begin
        w_nx_err = w_resp_err;
        w_nx_mem = w_done_data;
      end else if ((r_state == S_IDLE) && r_pend) begin
        w_nx_err = r_pend_err;
        w_nx_mem = r_pend_data;
      end else if ((r_state == S_IDLE) && !w_start) begin
        w_nx_err = w_memop && w_misal;
      end else begin
        w_bubble = 1'b1;
      end
    end
    w_nx_vld  = !w_bubble && i_valid_instr;
    w_nx_rdw  = !w_bubble && i_rd_write && !w_nx_err;
    w_nx_jump = !w_bubble && i_jump;
    w_nx_wbs  = !w_bubble && i_wb_src;
    w_nx_pc   = w_bubble ? '0 : i_pc;
    w_nx_alu  = w_bubble ? '0 : i_alu_data;
    w_nx_rd   = w_bubble ? '0 : i_rd_addr;
    if (w_bubble) w_nx_err = 1'b0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      o_valid_instr <= 1'b0;
      o_mem_err     <= 1'b0;
      o_rd_write    <= 1'b0;
      o_jump        <= 1'b0;
      o_wb_src      <= 1'b0;
      o_pc          <= '0;
      o_alu_data    <= '0;
      o_mem_data    <= '0;
      o_rd_addr     <= '0;
    end else if (w_wb_ld) begin
      o_valid_instr <= w_nx_vld;
      o_mem_err     <= w_nx_err;
      o_rd_write    <= w_nx_rdw;
      o_jump        <= w_nx_jump;
      o_wb_src      <= w_nx_wbs;
      o_pc          <= w_nx_pc;
      o_alu_data    <= w_nx_alu;
      o_mem_data    <= w_nx_mem;
      o_rd_addr     <= w_nx_rd;
    end
  end

endmodule

// File: doc/riscv_pu_memory_unit.md
# riscv_pu_memory_unit

Memory-access stage of the pipelined RISC-V core. It sits directly downstream of the execution unit and consumes its EX/MEM outputs. Loads and stores are issued as single AXI4-Lite master transactions. The upstream pipeline is stalled until each transaction's response arrives. The block then registers the MEM/WB bundle, with load data extended per access width, for the write-back stage.

## Interface
- ADDR_WIDTH, 64, AXI address width; the low ADDR_WIDTH bits of i_alu_data are used.
- DATA_WIDTH, 64, datapath and AXI data width (8 byte lanes).

Ports:
- clk  in  1  core clock
- nreset  in  1  reset; one clock; asynchronous, active-low
- enable  in  1  pipeline advance enable
- i_width  in  3  funct3 access width: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- i_jump, i_rd_write, i_read, i_write, i_wb_src, i_valid_instr  in  1 each  EX/MEM control
- i_pc, i_alu_data, i_rs2_data  in  DATA_WIDTH each  link PC, effective address / ALU result, store data
- i_rd_addr  in  5  destination register
- o_stall  out  1  holds upstream stages
- o_jump, o_rd_write, o_wb_src, o_valid_instr, o_mem_err  out  1 each  MEM/WB control
- o_pc, o_alu_data, o_mem_data  out  DATA_WIDTH each  MEM/WB data
- o_rd_addr  out  5
- m_araddr out ADDR_WIDTH; m_arvalid out 1; m_arready in 1
- m_rdata in DATA_WIDTH; m_rresp in 2; m_rvalid in 1; m_rready out 1
- m_awaddr out ADDR_WIDTH; m_awvalid out 1; m_awready in 1
- m_wdata out DATA_WIDTH; m_wstrb out 8; m_wvalid out 1; m_wready in 1
- m_bresp in 2; m_bvalid in 1; m_bready out 1

## Operation
- Memory op definition: i_valid_instr && (i_read || i_write) && enable. i_read and i_write are never both set.
- Misalignment: address not aligned to its width (H: a[0]; W/WU: a[1:0]; D: a[2:0]).
  - No bus transaction is issued and no stall occurs.
  - The instruction passes with o_mem_err=1 and o_rd_write=0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - An aligned load latches its address and goes to RD_ADDR.
  - An aligned store latches address, data and strobe, then goes to WR_REQ.
  - Any other instruction registers into MEM/WB on the same edge.
- RD_ADDR: m_arvalid=1 until m_arready, then RD_DATA.
- RD_DATA: m_rready=1. On m_rvalid, load data is formatted and registered, then back to IDLE.
- WR_REQ: m_awvalid and m_wvalid assert together. Each drops independently on its own ready. Once both channels have handshaken, go to WR_RESP.
- WR_RESP: m_bready=1. On m_bvalid, MEM/WB registers are written, then back to IDLE.
- Store data and strobe, with lane = addr[2:0]:
  - m_wdata = i_rs2_data << (8·lane).
  - m_wstrb = {1,3,F,FF}[width] << lane.
- Load format: the byte/half/word at lane is extracted from m_rdata. It is sign-extended for B/H/W and zero-extended for BU/HU/WU; D is passed as-is.
- o_mem_data = formatted load data for loads, otherwise 0.
- Error response: m_rresp≠0 or m_bresp≠0 gives o_mem_err=1 and o_rd_write=0 on that instruction.
- AXI addresses carry the full byte address.
- Once asserted, a valid is held stable until its ready arrives, regardless of enable.

## Timing
- Reset: FSM=IDLE; all o_* and all m_* outputs are 0.
- o_stall = (state≠IDLE) || (IDLE && aligned memory op present). It is combinational and drops in the response-handshake cycle.
- Non-memory instruction: 1-cycle latency; inputs at cycle N appear on outputs at N+1.
- Load with zero-wait slave: op at cycle 0, m_arvalid at cycle 1, m_rready at cycle 2, outputs valid at cycle 3. o_stall is high in cycles 0–1.
- Each extra arready/rvalid/awready/wready/bvalid wait cycle adds 1 cycle.
- Upstream inputs are held constant while o_stall=1.
- Cycles in which a new instruction is not captured: o_valid_instr is 0 (bubble).
- enable=0 in IDLE: outputs hold and no new transaction starts. In-flight transactions still complete; the result is registered on the first cycle with enable=1.
- Asynchronous reset mid-transaction: immediate return to IDLE with all valids deasserted. An outstanding response is not waited for.

## Test plan
- ALU op, i_alu_data=0x1234, rd=5, rd_write=1 → next cycle o_alu_data=0x1234, o_rd_addr=5, o_stall never high.
- LB at address 0x1003, zero-wait slave, m_rdata=0x00000000_80000000 → m_araddr=0x1003; at cycle 3 o_mem_data=0xFFFFFFFF_FFFFFF80, o_stall high for 2 cycles.
- SH at address 0x1006, rs2=0xABCD → m_wdata=0xABCD0000_00000000, m_wstrb=0xC0. With awready delayed 3 cycles and wready immediate, completion occurs only after the B handshake.
- LWU at address 0x1004 with m_rresp=2 → o_mem_err=1, o_rd_write=0.
- LD at address 0x1004 → no AR transaction, o_mem_err=1, next-cycle passthrough.
- nreset asserted while in RD_DATA → all m_* outputs 0 immediately; after release, a new load completes normally.
